// File: rtl/quantize_drain_if.sv
// Accumulator-row input stream and quantized SRAM write-out bus for quantize_drain.
// The slave modport is the quantize_drain view; master is the upstream/downstream neighbour view.
interface quantize_drain_if #(
   parameter int unsigned ARRAY_SIZE        = 8,
   parameter int unsigned ACC_DATA_WIDTH    = 32,
   parameter int unsigned OUTPUT_DATA_WIDTH = 16
);
   logic                                    acc_valid;
   logic [ARRAY_SIZE*ACC_DATA_WIDTH-1:0]    acc_data;
   logic                                    sram_write_enable;
   logic [1:0]                              data_set;
   logic [5:0]                              matrix_index;
   logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data;

   modport master (
      output acc_valid, acc_data,
      input  sram_write_enable, data_set, matrix_index, quantized_data
   );

   modport slave (
      input  acc_valid, acc_data,
      output sram_write_enable, data_set, matrix_index, quantized_data
   );
endinterface

// File: rtl/quantize_drain.sv
// Rounds, shifts and saturates systolic-array accumulator rows into tagged SRAM write rows.
// Define SAT_COUNT_EN to build the saturated-lane counter; otherwise sat_count is tied to 0.
module quantize_drain #(
   parameter int unsigned ARRAY_SIZE        = 8,
   parameter int unsigned ACC_DATA_WIDTH    = 32,
   parameter int unsigned OUTPUT_DATA_WIDTH = 16,
   parameter int unsigned NUM_SETS          = 2
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            start,
   input  logic [4:0]      shift_amt,
   output logic            busy,
   output logic            done,
   output logic [15:0]     sat_count,
   quantize_drain_if.slave bus
);
   localparam int unsigned RW       = ACC_DATA_WIDTH + 1;
   localparam logic [5:0]  LastRow  = 6'(2 * ARRAY_SIZE - 1);
   localparam logic [1:0]  LastSet  = 2'(NUM_SETS - 1);
   localparam logic [4:0]  MaxShift = 5'(ACC_DATA_WIDTH - 1);
   localparam logic [RW-1:0] OutMax =
      {{(RW - OUTPUT_DATA_WIDTH + 1){1'b0}}, {(OUTPUT_DATA_WIDTH - 1){1'b1}}};
   localparam logic [RW-1:0] OutMin =
      {{(RW - OUTPUT_DATA_WIDTH + 1){1'b1}}, {(OUTPUT_DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e     state_q, state_d;
   logic       flush_q, flush_d;
   logic [4:0] shift_q, shift_d;
   logic [5:0] row_q, row_d;
   logic [1:0] set_q, set_d;
   logic       start_ok, accept;

   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      shift_d  = shift_q;
      row_d    = row_q;
      set_d    = set_q;
      start_ok = 1'b0;
      accept   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = StRun;
               shift_d  = ({27'd0, shift_amt} >= ACC_DATA_WIDTH) ? MaxShift : shift_amt;
               row_d    = '0;
               set_d    = '0;
            end
         end
         StRun: begin
            flush_d = 1'b0;
            if (bus.acc_valid) begin
               accept = 1'b1;
               if (row_q == LastRow) begin
                  row_d = '0;
                  set_d = set_q + 2'd1;
                  if (set_q == LastSet) state_d = StFlush;
               end else begin
                  row_d = row_q + 6'd1;
               end
            end
         end
         StFlush: begin
            flush_d = 1'b1;
            if (flush_q) state_d = StDone;
         end
         StDone: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= StIdle;
         flush_q <= 1'b0;
         shift_q <= '0;
         row_q   <= '0;
         set_q   <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         shift_q <= shift_d;
         row_q   <= row_d;
         set_q   <= set_d;
      end
   end

   assign busy = (state_q == StRun) || (state_q == StFlush);
   assign done = (state_q == StDone);

   // Stage 1: add the half-LSB rounding bias in one extra bit so the sum cannot wrap.
   logic [RW-1:0]                 bias;
   logic [ACC_DATA_WIDTH-1:0]     lane;
   logic [ARRAY_SIZE-1:0][RW-1:0] round_d;
   logic [ARRAY_SIZE-1:0][RW-1:0] s1_data_q;
   logic                          s1_valid_q;
   logic [1:0]                    s1_set_q;
   logic [5:0]                    s1_row_q;

   always_comb begin
      bias    = '0;
      lane    = '0;
      round_d = '0;
      if (shift_q != 5'd0) bias = RW'(1) << (shift_q - 5'd1);
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         lane       = bus.acc_data[i*ACC_DATA_WIDTH +: ACC_DATA_WIDTH];
         round_d[i] = {lane[ACC_DATA_WIDTH-1], lane} + bias;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         s1_valid_q <= 1'b0;
         s1_set_q   <= '0;
         s1_row_q   <= '0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         s1_set_q   <= set_q;
         s1_row_q   <= row_q;
         s1_data_q  <= round_d;
      end
   end

   // Stage 2: arithmetic shift, then clamp to the signed output range.
   logic [ARRAY_SIZE-1:0][RW-1:0]                shifted;
   logic [ARRAY_SIZE-1:0][OUTPUT_DATA_WIDTH-1:0] quant_d;
   logic [ARRAY_SIZE-1:0]                        clamp_d;

   always_comb begin
      shifted = '0;
      quant_d = '0;
      clamp_d = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         shifted[i] = $signed(s1_data_q[i]) >>> shift_q;
         if ($signed(shifted[i]) > $signed(OutMax)) begin
            quant_d[i] = OutMax[OUTPUT_DATA_WIDTH-1:0];
            clamp_d[i] = 1'b1;
         end else if ($signed(shifted[i]) < $signed(OutMin)) begin
            quant_d[i] = OutMin[OUTPUT_DATA_WIDTH-1:0];
            clamp_d[i] = 1'b1;
         end else begin
            quant_d[i] = shifted[i][OUTPUT_DATA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         bus.sram_write_enable <= 1'b0;
         bus.data_set          <= '0;
         bus.matrix_index      <= '0;
         bus.quantized_data    <= '0;
      end else begin
         bus.sram_write_enable <= s1_valid_q;
         bus.data_set          <= s1_valid_q ? s1_set_q : 2'd0;
         bus.matrix_index      <= s1_valid_q ? s1_row_q : 6'd0;
         bus.quantized_data    <= s1_valid_q ? quant_d : '0;
      end
   end

`ifdef SAT_COUNT_EN
   logic [15:0] sat_q;
   logic [16:0] sat_sum;

   always_comb begin
      sat_sum = {1'b0, sat_q};
      if (s1_valid_q) begin
         for (int i = 0; i < ARRAY_SIZE; i++) sat_sum = sat_sum + 17'(clamp_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (srst || start_ok) begin
         sat_q <= '0;
      end else begin
         sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end

   assign sat_count = sat_q;
`else
   logic unused_clamp;
   assign unused_clamp = ^{clamp_d, start_ok};
   assign sat_count    = 16'd0;
`endif
endmodule

// File: tb/tb_quantize_drain.sv
// Directed bench for quantize_drain: reset, full runs, rounding/saturation rows,
// acc_valid bubbles, ignored start pulses and mid-run abort.
module tb_quantize_drain;
   localparam int unsigned AS = 8;
   localparam int unsigned AW = 32;
   localparam int unsigned OW = 16;

   typedef logic [AS*AW-1:0] acc_row_t;
   typedef logic [AS*OW-1:0] out_row_t;

   typedef struct {
      logic [4:0]  sh;
      int          x [8];
      int          q [8];
      logic [15:0] sat;
   } vec_t;

   logic        clk;
   logic        srst;
   logic        start;
   logic [4:0]  shift_amt;
   logic        busy;
   logic        done;
   logic [15:0] sat_count;

   quantize_drain_if #(
      .ARRAY_SIZE        (AS),
      .ACC_DATA_WIDTH    (AW),
      .OUTPUT_DATA_WIDTH (OW)
   ) bus ();

   quantize_drain #(
      .ARRAY_SIZE        (AS),
      .ACC_DATA_WIDTH    (AW),
      .OUTPUT_DATA_WIDTH (OW),
      .NUM_SETS          (2)
   ) dut (
      .clk       (clk),
      .srst      (srst),
      .start     (start),
      .shift_amt (shift_amt),
      .busy      (busy),
      .done      (done),
      .sat_count (sat_count),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int       total;
   int       bad;
   acc_row_t row_data [32];
   out_row_t row_exp  [32];
   vec_t     vecs [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int cyc, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (cycle %0d): got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic load_ramp();
      for (int b = 0; b < 32; b++) begin
         for (int i = 0; i < AS; i++) begin
            row_data[b][i*AW +: AW] = 32'(b + i);
            row_exp[b][i*OW +: OW]  = 16'(b + i);
         end
      end
   endtask

   task automatic load_vec(input int k);
      for (int b = 0; b < 32; b++) begin
         row_data[b] = '0;
         row_exp[b]  = '0;
      end
      for (int i = 0; i < AS; i++) begin
         row_data[0][i*AW +: AW] = 32'(vecs[k].x[i]);
         row_exp[0][i*OW +: OW]  = 16'(vecs[k].q[i]);
      end
   endtask

   // One complete run; gaps bit c drops acc_valid in run cycle c.
   task automatic run(input logic [4:0] sh, input logic [63:0] gaps, input logic [15:0] exp_sat);
      int in_beat [80];
      int beat;
      int last;
      int vb;
      beat = 0;
      last = 0;
      for (int c = 0; c < 64; c++) begin
         if (!gaps[c]) begin
            if (beat == 31) begin
               last = c;
               break;
            end
            beat++;
         end
      end
      for (int c = 0; c < 80; c++) in_beat[c] = -1;
      bus.acc_valid = 1'b0;
      start         = 1'b1;
      shift_amt     = sh;
      step();
      beat = 0;
      for (int c = 0; c <= last + 4; c++) begin
         // stray start pulses in RUN and in DONE must be ignored
         start     = (c == 3) || (c == last + 3);
         shift_amt = start ? ~sh : sh;
         if (c <= last && !gaps[c]) begin
            bus.acc_valid = 1'b1;
            bus.acc_data  = row_data[beat];
            in_beat[c]    = beat;
            beat++;
         end else begin
            bus.acc_valid = (c > last);
            bus.acc_data  = '1;
         end
         vb = (c >= 2) ? in_beat[c-2] : -1;
         chk("busy", c, 128'(busy), 128'(c <= last + 2));
         chk("done", c, 128'(done), 128'(c == last + 3));
         chk("sram_write_enable", c, 128'(bus.sram_write_enable), 128'(vb >= 0));
         chk("data_set", c, 128'(bus.data_set), (vb >= 0) ? 128'(vb / 16) : 128'(0));
         chk("matrix_index", c, 128'(bus.matrix_index), (vb >= 0) ? 128'(vb % 16) : 128'(0));
         chk("quantized_data", c, 128'(bus.quantized_data),
             (vb >= 0) ? 128'(row_exp[vb]) : 128'(0));
         step();
      end
      start         = 1'b0;
      bus.acc_valid = 1'b0;
      chk("idle_after_done", last + 5, 128'(busy), 128'(0));
      chk("sat_count", last + 5, 128'(sat_count), 128'(exp_sat));
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      srst          = 1'b1;
      start         = 1'b0;
      shift_amt     = 5'd0;
      bus.acc_valid = 1'b1;
      bus.acc_data  = '1;

      vecs[0] = '{5'd4, '{23, 24, -24, -25, 8, 7, -8, 0}, '{1, 2, -1, -2, 1, 0, 0, 0}, 16'd0};
      vecs[1] = '{5'd0, '{40000, -40000, 32767, -32768, 0, 1, -1, 100},
                  '{32767, -32768, 32767, -32768, 0, 1, -1, 100}, 16'd2};
      vecs[2] = '{5'd16, '{32'sh7FFF8000, 32'sh7FFF7FFF, 32'sh80000000, 65535, 32767, 32768,
                  -32768, -32769}, '{32767, 32767, -32768, 1, 0, 1, 0, -1}, 16'd1};
      vecs[3] = '{5'd31, '{32'sh7FFFFFFF, 32'sh80000000, 32'sh3FFFFFFF, 32'sh40000000,
                  -1073741824, -1073741825, 0, 1}, '{1, -1, 0, 1, 0, -1, 0, 0}, 16'd0};

      // Reset held two cycles with acc_valid high.
      step();
      step();
      chk("rst_we", 0, 128'(bus.sram_write_enable), 128'(0));
      chk("rst_busy", 0, 128'(busy), 128'(0));
      chk("rst_done", 0, 128'(done), 128'(0));
      chk("rst_set", 0, 128'(bus.data_set), 128'(0));
      chk("rst_index", 0, 128'(bus.matrix_index), 128'(0));
      chk("rst_data", 0, 128'(bus.quantized_data), 128'(0));
      chk("rst_sat", 0, 128'(sat_count), 128'(0));
      srst = 1'b0;
      step();
      chk("idle_we", 1, 128'(bus.sram_write_enable), 128'(0));
      chk("idle_busy", 1, 128'(busy), 128'(0));

      // Rounding / saturation table rows, each carried as row 0 of its own run.
      for (int k = 0; k < 4; k++) begin
         load_vec(k);
`ifdef SAT_COUNT_EN
         run(vecs[k].sh, 64'd0, vecs[k].sat);
`else
         run(vecs[k].sh, 64'd0, 16'd0);
`endif
      end

      // Full ramp run, then the bubble pattern 1,0,1,1,0,1.
      load_ramp();
      run(5'd0, 64'd0, 16'd0);
      run(5'd0, 64'h12, 16'd0);

      // Abort after row 5 of set 0.
      start     = 1'b1;
      shift_amt = 5'd0;
      step();
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.acc_valid = 1'b1;
         bus.acc_data  = row_data[c];
         step();
      end
      chk("abort_pre_we", 6, 128'(bus.sram_write_enable), 128'(1));
      chk("abort_pre_index", 6, 128'(bus.matrix_index), 128'(4));
      srst = 1'b1;
      step();
      srst = 1'b0;
      for (int c = 7; c < 17; c++) begin
         chk("abort_we", c, 128'(bus.sram_write_enable), 128'(0));
         chk("abort_busy", c, 128'(busy), 128'(0));
         chk("abort_done", c, 128'(done), 128'(0));
         step();
      end
      bus.acc_valid = 1'b0;
      run(5'd0, 64'd0, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/quantize_drain.md
Name: quantize_drain

Overview:
- Upstream neighbour of the SRAM write-out stage. Accepts rows of wide accumulator results drained from the systolic array.
- Applies rounding right-shift and signed saturation to OUTPUT_DATA_WIDTH per lane.
- Emits each row with its sram_write_enable / data_set / matrix_index tags, sequenced by an internal row/set counter and run FSM.

Parameters:
- ARRAY_SIZE, 8, lanes per row; rows per set = 2*ARRAY_SIZE.
- ACC_DATA_WIDTH, 32, signed accumulator width per lane.
- OUTPUT_DATA_WIDTH, 16, signed quantized width per lane.
- NUM_SETS, 2, data sets per run (data_set 0..NUM_SETS-1).

Ports:
- clk  input  1  clock, all logic on rising edge
- srst  input  1  synchronous reset, active-high
- start  input  1  one-cycle run start pulse; honoured only in IDLE
- shift_amt  input  5  right-shift amount, latched on accepted start
- acc_valid  input  1  acc_data holds a valid row this cycle
- acc_data  input  ARRAY_SIZE*ACC_DATA_WIDTH  signed lanes, lane i at [i*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse at end of run
- sram_write_enable  output  1  quantized_data/data_set/matrix_index valid
- data_set  output  2  set tag of emitted row
- matrix_index  output  6  row tag, 0..2*ARRAY_SIZE-1
- quantized_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed lanes, same lane order as input
- sat_count  output  16  saturated-lane count for current/last run

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; counters and latched shift are 0. srst mid-run aborts immediately. No done pulse; in-flight pipeline rows are discarded.
- FSM states:
  - IDLE: start -> RUN; latch shift_amt; clear row_idx, set_idx, sat_count.
  - RUN: a beat is accepted when acc_valid=1. Each beat is tagged (set_idx, row_idx). row_idx increments and wraps at 2*ARRAY_SIZE-1 to 0, incrementing set_idx. The beat tagged (NUM_SETS-1, 2*ARRAY_SIZE-1) moves FSM to FLUSH.
  - FLUSH: 2 cycles, lets the pipeline drain, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- acc_valid outside RUN is ignored. start outside IDLE is ignored. A start in the same cycle as done is ignored.
- Pipeline: 2 register stages. A beat accepted in cycle N appears on the outputs in cycle N+2 with sram_write_enable=1. Back-to-back beats give back-to-back outputs. A gap in acc_valid gives sram_write_enable=0 in the matching output cycle. When sram_write_enable=0, quantized_data, data_set and matrix_index are 0.
- Stage 1 (round), per lane, in ACC_DATA_WIDTH+1 bits:
  - shift=0: r = x.
  - shift>0: r = x + (1 << (shift-1)), i.e. round half up.
- Stage 2 (shift and saturate): q = r >>> shift (arithmetic).
  - q > 2^(OUTPUT_DATA_WIDTH-1)-1 -> output max.
  - q < -2^(OUTPUT_DATA_WIDTH-1) -> output min.
  - Otherwise output the low OUTPUT_DATA_WIDTH bits of q.
- shift_amt >= ACC_DATA_WIDTH is treated as ACC_DATA_WIDTH-1.
- Tag and valid bits travel in the same pipeline registers as the data.
- The last output row appears in the 2nd FLUSH cycle; done asserts the following cycle.

Optional Feature:
- SAT_COUNT_EN defined: sat_count increments by the number of lanes clamped in stage 2 each output cycle. It saturates at 16'hFFFF, clears on accepted start, and holds its value after done until the next start.
- SAT_COUNT_EN undefined: sat_count is constant 0 and no counting logic is built.

Test Plan:
- Reset: srst=1 for 2 cycles with acc_valid=1 -> all outputs 0, busy=0, no sram_write_enable.
- Full run: start with shift_amt=0, then 32 consecutive beats with lane i = row+i.
  - Outputs appear 2 cycles after each beat: data_set 0 for rows 0..15, then data_set 1 for rows 0..15, matrix_index 0..15 within each set.
  - done pulses exactly 1 cycle after the last output; busy drops with done.
- Rounding, shift_amt=4:
  - Lane values 23, 24, -24, -25 -> 1, 2, -1, -2.
  - Lane value 8 -> 1 (half rounds up).
- Saturation, shift_amt=0:
  - Lane values 40000, -40000, 32767, -32768 -> 32767, -32768, 32767, -32768.
  - With SAT_COUNT_EN, sat_count=2 after that row.
- Bubbles: acc_valid pattern 1,0,1,1,0,1 -> sram_write_enable pattern 1,0,1,1,0,1 delayed by 2 cycles; matrix_index 0,1,2,3 on the valid cycles only.
- Abort: srst asserted after row 5 of set 0 -> no further sram_write_enable, no done. A fresh start then restarts at data_set 0, matrix_index 0.
